// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment scanner with tear-free frame update,
// leading-zero blanking and inter-digit ghosting gaps. All outputs are registered.
module seven_seg_scan #(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          SEG_POLARITY   = 1'b0,
  parameter bit          DIGIT_POLARITY = 1'b0
) (
  input  logic        clk,
  input  logic        n_sync_reset,
  input  logic [15:0] value_i,
  input  logic        load_i,
  input  logic [3:0]  dp_i,
  input  logic        blank_lz_i,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [3:0]  digit_o,
  output logic        frame_o
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  // Unlit / inactive levels depend on polarity.
  localparam logic [6:0] SEG_OFF   = {7{~SEG_POLARITY}};
  localparam logic       DP_OFF    = ~SEG_POLARITY;
  localparam logic [3:0] DIGIT_OFF = {4{~DIGIT_POLARITY}};

  typedef enum logic {SHOW, BLANK} state_t;

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_start;

  logic [15:0] pend_val_q, disp_val_q, disp_val_d;
  logic [3:0]  pend_dp_q,  disp_dp_q,  disp_dp_d;

  logic [3:0]  nib;
  logic        lz_blank;
  logic [6:0]  seg_lit;
  logic        dp_lit;
  logic [3:0]  digit_sel;

  // Hex glyphs, gfedcba, 1 = lit.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  // Scan sequencer next state; frame start is the BLANK->SHOW step into digit 0.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q + 1'b1;
    frame_start = 1'b0;
    case (state_q)
      SHOW: if (cnt_q == SHOW_LAST) begin
        state_d = BLANK;
        cnt_d   = '0;
      end
      default: if (cnt_q == BLANK_LAST) begin
        state_d     = SHOW;
        idx_d       = idx_q + 2'd1;
        cnt_d       = '0;
        frame_start = (idx_q == 2'd3);
      end
    endcase
    disp_val_d = frame_start ? pend_val_q : disp_val_q;
    disp_dp_d  = frame_start ? pend_dp_q  : disp_dp_q;
  end

  // Output decode from next-state values so registered outputs line up with the state.
  always_comb begin
    nib = disp_val_d[{idx_d, 2'b00} +: 4];
    case (idx_d)
      2'd1:    lz_blank = blank_lz_i && (disp_val_d[15:4]  == 12'h000);
      2'd2:    lz_blank = blank_lz_i && (disp_val_d[15:8]  == 8'h00);
      2'd3:    lz_blank = blank_lz_i && (disp_val_d[15:12] == 4'h0);
      default: lz_blank = 1'b0;
    endcase
    seg_lit   = (state_d == SHOW && !lz_blank) ? glyph(nib) : 7'h00;
    dp_lit    = (state_d == SHOW) && disp_dp_d[idx_d];
    digit_sel = (state_d == SHOW) ? (4'b0001 << idx_d) : 4'b0000;
  end

  // State, capture registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!n_sync_reset) begin
      state_q    <= BLANK;
      idx_q      <= 2'd3;
      cnt_q      <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      seg_o      <= SEG_OFF;
      dp_o       <= DP_OFF;
      digit_o    <= DIGIT_OFF;
      frame_o    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      if (load_i) begin
        pend_val_q <= value_i;
        pend_dp_q  <= dp_i;
      end
      seg_o   <= SEG_POLARITY   ? seg_lit   : ~seg_lit;
      dp_o    <= SEG_POLARITY   ? dp_lit    : ~dp_lit;
      digit_o <= DIGIT_POLARITY ? digit_sel : ~digit_sel;
      frame_o <= frame_start;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan at REFRESH_DIV=4, BLANK_CYCLES=2, active-low outputs.
// Frame = 24 cycles: digit d shows at frame cycles d*6+0..3, gap at d*6+4..5.
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        n_sync_reset = 1'b0;
  logic [15:0] value_i = '0;
  logic        load_i = 1'b0;
  logic [3:0]  dp_i = '0;
  logic        blank_lz_i = 1'b0;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  digit_o;
  logic        frame_o;

  int total = 0;
  int bad   = 0;

  // leading-zero vectors and expected active-low glyphs for digits 0..3
  logic [15:0] lz_val [3] = '{16'h0005, 16'h0100, 16'h0000};
  logic [6:0]  lz_exp [3][4] = '{'{7'h12, 7'h7F, 7'h7F, 7'h7F},
                                 '{7'h40, 7'h40, 7'h79, 7'h7F},
                                 '{7'h40, 7'h7F, 7'h7F, 7'h7F}};

  seven_seg_scan #(
    .REFRESH_DIV(4), .BLANK_CYCLES(2), .SEG_POLARITY(1'b0), .DIGIT_POLARITY(1'b0)
  ) dut (
    .clk(clk), .n_sync_reset(n_sync_reset), .value_i(value_i), .load_i(load_i),
    .dp_i(dp_i), .blank_lz_i(blank_lz_i), .seg_o(seg_o), .dp_o(dp_o),
    .digit_o(digit_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  // Advance to the negedge where frame_o is seen high (frame cycle 0), bounded.
  task automatic wait_frame();
    int n = 0;
    do begin @(negedge clk); n++; end while (frame_o !== 1'b1 && n < 100);
    total++;
    if (frame_o !== 1'b1) begin
      bad++;
      $display("FAIL frame_wait: frame_o=%b required=1 within 100 cycles", frame_o);
    end
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    n_sync_reset = 1'b0;
    repeat (3) @(negedge clk);
    obs = {digit_o, seg_o, dp_o, frame_o}; total++;
    if (obs !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin bad++;
      $display("FAIL rst_hold: got %h need %h", obs, {4'hF, 7'h7F, 1'b1, 1'b0}); end
    n_sync_reset = 1'b1;
    @(negedge clk);
    obs = {digit_o, seg_o, dp_o, frame_o}; total++;
    if (obs !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin bad++;
      $display("FAIL rst_gap: got %h need %h", obs, {4'hF, 7'h7F, 1'b1, 1'b0}); end
    @(negedge clk);
    obs = {digit_o, seg_o, dp_o, frame_o}; total++;
    if (obs !== {4'hE, 7'h40, 1'b1, 1'b1}) begin bad++;
      $display("FAIL rst_first_show: got %h need %h", obs, {4'hE, 7'h40, 1'b1, 1'b1}); end
    @(negedge clk);
    obs = {digit_o, seg_o, dp_o, frame_o}; total++;
    if (obs !== {4'hE, 7'h40, 1'b1, 1'b0}) begin bad++;
      $display("FAIL rst_frame_pulse_len: got %h need %h", obs, {4'hE, 7'h40, 1'b1, 1'b0}); end
  endtask

  task automatic test_load_glyphs();
    logic [6:0]  exp_seg [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
    logic [3:0]  oh;
    logic [12:0] obs, exp;
    blank_lz_i = 1'b0;
    wait_frame();
    value_i = 16'h12AF; dp_i = 4'b0001; load_i = 1'b1;
    @(negedge clk); load_i = 1'b0;
    wait_frame();
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      oh = 4'b0001 << (c / 6);
      if (c % 6 < 4) exp = {~oh, exp_seg[c / 6], (c / 6) != 0, c == 0};
      else           exp = {4'hF, 7'h7F, 1'b1, 1'b0};
      obs = {digit_o, seg_o, dp_o, frame_o}; total++;
      if (obs !== exp) begin bad++;
        $display("FAIL glyph_frame c=%0d: got %h need %h", c, obs, exp); end
    end
  endtask

  // Two loads in one frame: current frame untouched, last load shown next frame.
  task automatic test_double_load();
    logic [6:0] old_seg [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c == 0) begin total++;
        if (frame_o !== 1'b1) begin bad++;
          $display("FAIL dbl_align: frame_o=%b need 1", frame_o); end
      end
      if (c % 6 == 0) begin total++;
        if (seg_o !== old_seg[c / 6]) begin bad++;
          $display("FAIL dbl_tear d=%0d: got %h need %h", c / 6, seg_o, old_seg[c / 6]); end
      end
      case (c)
        0: begin value_i = 16'h1111; load_i = 1'b1; end
        5: begin value_i = 16'h2222; load_i = 1'b1; end
        default: load_i = 1'b0;
      endcase
    end
    load_i = 1'b0;
    wait_frame();
    for (int c = 0; c <= 18; c++) begin
      if (c > 0) @(negedge clk);
      if (c % 6 == 0) begin total++;
        if (seg_o !== 7'h24) begin bad++;
          $display("FAIL dbl_last_wins d=%0d: got %h need %h", c / 6, seg_o, 7'h24); end
      end
    end
  endtask

  // Load on the frame-start edge itself applies one frame later.
  task automatic test_same_edge();
    repeat (5) @(negedge clk);
    value_i = 16'h3333; load_i = 1'b1;
    @(negedge clk); load_i = 1'b0;
    total++;
    if ({frame_o, seg_o} !== {1'b1, 7'h24}) begin bad++;
      $display("FAIL same_edge_cur: got %h need %h", {frame_o, seg_o}, {1'b1, 7'h24}); end
    wait_frame();
    total++;
    if (seg_o !== 7'h30) begin bad++;
      $display("FAIL same_edge_next: got %h need %h", seg_o, 7'h30); end
  endtask

  task automatic test_lz();
    logic [3:0] oh;
    blank_lz_i = 1'b1; dp_i = 4'b0000;
    for (int v = 0; v < 3; v++) begin
      value_i = lz_val[v]; load_i = 1'b1;
      @(negedge clk); load_i = 1'b0;
      wait_frame();
      for (int c = 0; c <= 18; c++) begin
        if (c > 0) @(negedge clk);
        if (c % 6 == 0) begin
          oh = 4'b0001 << (c / 6); total++;
          if ({digit_o, seg_o, dp_o} !== {~oh, lz_exp[v][c / 6], 1'b1}) begin bad++;
            $display("FAIL lz v=%h d=%0d: got %h need %h", lz_val[v], c / 6,
                     {digit_o, seg_o, dp_o}, {~oh, lz_exp[v][c / 6], 1'b1}); end
        end
      end
    end
    blank_lz_i = 1'b0;
  endtask

  // Reset mid-SHOW of digit 2 clears pending/displayed and restarts the scan.
  task automatic test_reset_mid();
    logic [12:0] obs;
    value_i = 16'h8888; load_i = 1'b1;
    @(negedge clk); load_i = 1'b0;
    wait_frame();
    repeat (13) @(negedge clk);
    total++;
    if ({digit_o, seg_o} !== {4'b1011, 7'h00}) begin bad++;
      $display("FAIL mid_pre: got %h need %h", {digit_o, seg_o}, {4'b1011, 7'h00}); end
    n_sync_reset = 1'b0;
    @(negedge clk);
    obs = {digit_o, seg_o, dp_o, frame_o}; total++;
    if (obs !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin bad++;
      $display("FAIL mid_rst: got %h need %h", obs, {4'hF, 7'h7F, 1'b1, 1'b0}); end
    n_sync_reset = 1'b1;
    @(negedge clk);
    obs = {digit_o, seg_o, dp_o, frame_o}; total++;
    if (obs !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin bad++;
      $display("FAIL mid_gap: got %h need %h", obs, {4'hF, 7'h7F, 1'b1, 1'b0}); end
    @(negedge clk);
    obs = {digit_o, seg_o, dp_o, frame_o}; total++;
    if (obs !== {4'hE, 7'h40, 1'b1, 1'b1}) begin bad++;
      $display("FAIL mid_restart: got %h need %h", obs, {4'hE, 7'h40, 1'b1, 1'b1}); end
    repeat (6) @(negedge clk);
    total++;
    if ({digit_o, seg_o} !== {4'b1101, 7'h40}) begin bad++;
      $display("FAIL mid_cleared: got %h need %h", {digit_o, seg_o}, {4'b1101, 7'h40}); end
  endtask

  task automatic test_free_run();
    logic [3:0] oh;
    logic [4:0] obs, exp;
    wait_frame();
    for (int c = 0; c < 48; c++) begin
      if (c > 0) @(negedge clk);
      oh  = 4'b0001 << ((c % 24) / 6);
      exp = {((c % 6) < 4) ? ~oh : 4'hF, (c % 24) == 0};
      obs = {digit_o, frame_o}; total++;
      if (obs !== exp) begin bad++;
        $display("FAIL free_run c=%0d: got %b need %b", c, obs, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_load_glyphs();
    test_double_load();
    test_same_edge();
    test_lz();
    test_reset_mid();
    test_free_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL provide parameter REFRESH_DIV, default 50000, meaning cycles each digit is driven (legal >= 2).
REQ-002 SHALL provide parameter BLANK_CYCLES, default 16, meaning all-digits-off cycles between digits (legal >= 1).
REQ-003 SHALL provide parameter SEG_POLARITY, default 0, meaning seg_o/dp_o level for a lit segment (1 = active-high).
REQ-004 SHALL provide parameter DIGIT_POLARITY, default 0, meaning digit_o level for a selected digit (1 = active-high).
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port n_sync_reset  input  1  one clock; reset is synchronous and active-low.
REQ-007 SHALL have port value_i  input  16  CPU display register, nibble k drives digit k (k=0 least significant).
REQ-008 SHALL have port load_i  input  1  capture strobe for value_i, dp_i.
REQ-009 SHALL have port dp_i  input  4  decimal point per digit.
REQ-010 SHALL have port blank_lz_i  input  1  leading-zero blanking enable.
REQ-011 SHALL have port seg_o  output  7  segments, bit0=a ... bit6=g.
REQ-012 SHALL have port dp_o  output  1  decimal point segment.
REQ-013 SHALL have port digit_o  output  4  one-hot digit select, bit k = digit k.
REQ-014 SHALL have port frame_o  output  1  one-cycle pulse at frame start.

Function
REQ-015 SHALL drive all outputs from registers only (no combinational path input->output).
REQ-016 SHALL run states SHOW and BLANK with digit index idx (0..3) and a cycle counter.
REQ-017 SHOW SHALL last exactly REFRESH_DIV cycles, then go to BLANK.
REQ-018 BLANK SHALL last exactly BLANK_CYCLES cycles, then go to SHOW with idx = (idx+1) mod 4 (3 wraps to 0).
REQ-019 In BLANK, digit_o SHALL be all inactive and seg_o, dp_o all unlit.
REQ-020 In SHOW, digit_o SHALL select only digit idx; seg_o SHALL be hex glyph of displayed nibble idx; dp_o SHALL be displayed dp[idx].
REQ-021 Glyphs (gfedcba, lit=1): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; output levels inverted when polarity parameter = 0.
REQ-022 load_i high at an edge SHALL copy value_i, dp_i into pending registers; last load before a frame start wins.
REQ-023 On each BLANK->SHOW transition into idx 0 (frame start), displayed registers SHALL copy pending as held before that edge; a load on the same edge applies at the following frame.
REQ-024 Displayed value SHALL never change mid-frame (tear-free).
REQ-025 With blank_lz_i=1, digit k>0 SHALL show unlit seg_o when nibbles k..3 are all zero; digit 0 never blanked; digit_o and dp_o unaffected.
REQ-026 frame_o SHALL be high exactly in the first SHOW cycle of idx 0, else low.
REQ-027 Frame period SHALL be 4*(REFRESH_DIV+BLANK_CYCLES) cycles.

Reset
REQ-028 n_sync_reset low at an edge SHALL set state BLANK, idx 3, counter 0, pending and displayed value/dp to 0, in any state including mid-SHOW.
REQ-029 While in reset, digit_o SHALL be inactive, seg_o and dp_o unlit, frame_o 0.
REQ-030 After release, first SHOW (idx 0, frame_o pulse) SHALL begin after BLANK_CYCLES cycles.

Verification (REFRESH_DIV=4, BLANK_CYCLES=2, polarities 0)
REQ-031 Release reset, no load -> 2 cycles digit_o=1111, then digit_o=1110, seg_o=40, dp_o=1, frame_o=1 for one cycle.
REQ-032 load 0x12AF, dp_i=0001, blank_lz_i=0 -> next frame seg_o per digit 0..3 = 0E,08,24,79; dp_o=0 only on digit 0.
REQ-033 Loads 0x1111 then 0x2222 within one frame -> current frame unchanged, next frame all digits seg_o=24.
REQ-034 value 0x0005, blank_lz_i=1 -> digit 0 seg_o=12, digits 1-3 seg_o=7F with digit_o still strobing; value 0x0000 -> digit 0 seg_o=40.
REQ-035 Reset asserted during digit 2 SHOW -> next edge all outputs inactive; after release display restarts per REQ-031 showing 0.
REQ-036 Free run -> each digit_o active exactly 4 cycles, 2-cycle gaps, frame_o period 24 cycles.
